ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
Multi-cycle control FSM for the 8-bit accumulator datapath. Drives the 2-bit source select of the shared 8-bit bus selector and all register-load, memory-write and ALU-op strobes. Sits directly upstream of the bus selector and sequences fetch, decode and execute. Latches the opcode from the bus, honours a memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 8, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
bus_in  in  8  selected bus value (bus selector output)
ac_zero  in  1  accumulator == 0
mem_ready  in  1  memory read data valid / write accepted this cycle
bus_sel  out  2  00=mem, 01=DR, 10=PC (zero-extended), 11=AC
ar_ld  out  1  AR <= bus[4:0]
pc_ld  out  1  PC <= bus[4:0]
pc_inc  out  1  PC <= PC+1 (5-bit wrap)
dr_ld  out  1  DR <= bus
ac_ld  out  1  AC <= ALU result
mem_we  out  1  write AC to M[AR]
alu_op  out  2  00=PASS(DR), 01=ADD(AC+DR, 8-bit wrap), 10=AND, 11=NOT(AC)
halted  out  1  HLT executed
instr_count  out  CNT_W  retired instructions, wraps to 0

Behaviour:
- Reset: asynchronous, active-low. rst_n low -> state IDLE, opcode reg 0, instr_count 0. All outputs 0 while in IDLE, including bus_sel=00 and halted=0.
- Outputs are Moore decodes of state/opcode, gated by mem_ready where noted. Only the listed strobe is high in each state; all others are 0. bus_sel defaults to 00.
- Instruction format: opcode = bus[7:5], address = bus[4:0].
- Opcodes: 000 LDA, 001 STA, 010 ADD, 011 AND, 100 JMP, 101 JZ, 110 NOT, 111 HLT.
- IDLE: no strobes -> FETCH1 unconditionally on the next edge.
- FETCH1: bus_sel=10, ar_ld=1 -> FETCH2.
- FETCH2: bus_sel=00.
  - mem_ready=1: dr_ld=1, pc_inc=1 -> FETCH3.
  - mem_ready=0: no strobes, stay in FETCH2.
- FETCH3: bus_sel=01, ar_ld=1; opcode reg <= bus_in[7:5] -> EXEC1.
- EXEC1 per opcode:
  - LDA/ADD/AND: bus_sel=00; dr_ld=mem_ready. Go to EXEC2 when mem_ready=1, else stay.
  - STA: bus_sel=11, mem_we=1 held until mem_ready=1, then retire -> FETCH1.
  - JMP: bus_sel=01, pc_ld=1, retire -> FETCH1.
  - JZ: bus_sel=01, pc_ld=ac_zero (sampled this cycle), retire -> FETCH1.
  - NOT: alu_op=11, ac_ld=1, retire -> FETCH1.
  - HLT: retire -> HALT.
- EXEC2 (LDA/ADD/AND only): bus_sel=01, ac_ld=1, alu_op=00/01/10 respectively, retire -> FETCH1.
- HALT: halted=1, no strobes, remains until rst_n low.
- Retire: instr_count += 1 on the edge leaving the final exec state, HLT included. Wraps 2^CNT_W-1 -> 0.
- Latency with mem_ready tied high, counting IDLE exit to next FETCH1:
  - LDA/ADD/AND: 5 cycles.
  - STA/JMP/JZ/NOT: 4 cycles.
  - Each mem_ready=0 cycle in FETCH2/EXEC1 adds exactly one cycle.
- pc_inc and pc_ld are never asserted together. PC wrap 31->0 is a datapath concern; the sequencer must not special-case it.
- Reset mid-instruction, including mid-wait: immediate return to IDLE. No partial strobe after reset assertion. Counter cleared.
- mem_ready is ignored outside FETCH2 and EXEC1 memory states.

Test Plan:
- Reset then release, mem_ready=1: IDLE 1 cycle all-zero outputs; FETCH1 shows bus_sel=10, ar_ld=1; FETCH2 dr_ld=pc_inc=1; FETCH3 bus_sel=01, ar_ld=1.
- bus_in=8'h45 at FETCH3 (ADD addr 5): EXEC1 bus_sel=00, dr_ld=1; EXEC2 alu_op=01, ac_ld=1; instr_count 0->1; back in FETCH1 5 cycles after leaving IDLE.
- STA (8'h23) with mem_ready low 3 cycles in EXEC1: mem_we=1 for 4 cycles with bus_sel=11; retire on 4th; no dr_ld/ac_ld.
- JZ (8'hA9): ac_zero=1 -> pc_ld=1 with bus_sel=01; repeat with ac_zero=0 -> pc_ld=0; both retire in 4 cycles.
- HLT (8'hE0): halted=1 permanently; all strobes 0 for 20 cycles; instr_count incremented once; rst_n pulse clears halted and count.
- rst_n asserted asynchronously mid-FETCH2 wait: outputs 0 before next clk edge. Separately, 2^CNT_W NOT instructions wrap instr_count to 0.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer -- multi-cycle control FSM for the 8-bit accumulator datapath.
//
// Sequences fetch / decode / execute, drives the 2-bit source select of the
// shared bus selector and every register-load, memory-write and ALU strobe.
// The opcode is latched from the bus in FETCH3; memory accesses wait on
// mem_ready; retired instructions are counted in instr_count.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus_in       selected bus value (bus selector output)
//   ac_zero      accumulator == 0
//   mem_ready    memory read data valid / write accepted this cycle
//   bus_sel      bus source: 00=mem, 01=DR, 10=PC, 11=AC
//   ar_ld        AR <= bus[4:0]
//   pc_ld        PC <= bus[4:0]
//   pc_inc       PC <= PC+1
//   dr_ld        DR <= bus
//   ac_ld        AC <= ALU result
//   mem_we       write AC to M[AR]
//   alu_op       00=PASS(DR), 01=ADD, 10=AND, 11=NOT(AC)
//   halted       HLT executed
//   instr_count  retired instructions, wraps to 0

module ctrl_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       bus_in,
    input  logic             ac_zero,
    input  logic             mem_ready,
    output logic [1:0]       bus_sel,
    output logic             ar_ld,
    output logic             pc_ld,
    output logic             pc_inc,
    output logic             dr_ld,
    output logic             ac_ld,
    output logic             mem_we,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_EXEC1,
        S_EXEC2,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_LDA = 3'b000,
        OP_STA = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_JMP = 3'b100,
        OP_JZ  = 3'b101,
        OP_NOT = 3'b110,
        OP_HLT = 3'b111
    } op_t;

    state_t state;
    op_t    opcode;
    logic   retire;

    // The address field is routed to AR/PC by the datapath, never decoded here.
    logic [4:0] addr_field_unused;
    assign addr_field_unused = bus_in[4:0];

    // Outputs are decoded from state/opcode (and mem_ready where a memory
    // access is pending) so that reset forces them low without waiting for
    // a clock edge and the wait states show no strobe at all.
    always_comb begin
        bus_sel = 2'b00;
        ar_ld   = 1'b0;
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        dr_ld   = 1'b0;
        ac_ld   = 1'b0;
        mem_we  = 1'b0;
        alu_op  = 2'b00;
        halted  = 1'b0;
        retire  = 1'b0;
        case (state)
            S_FETCH1: begin
                bus_sel = 2'b10;
                ar_ld   = 1'b1;
            end
            S_FETCH2: begin
                dr_ld  = mem_ready;
                pc_inc = mem_ready;
            end
            S_FETCH3: begin
                bus_sel = 2'b01;
                ar_ld   = 1'b1;
            end
            S_EXEC1: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_AND: dr_ld = mem_ready;
                    OP_STA: begin
                        bus_sel = 2'b11;
                        mem_we  = 1'b1;
                        retire  = mem_ready;
                    end
                    OP_JMP: begin
                        bus_sel = 2'b01;
                        pc_ld   = 1'b1;
                        retire  = 1'b1;
                    end
                    OP_JZ: begin
                        bus_sel = 2'b01;
                        pc_ld   = ac_zero;
                        retire  = 1'b1;
                    end
                    OP_NOT: begin
                        alu_op = 2'b11;
                        ac_ld  = 1'b1;
                        retire = 1'b1;
                    end
                    default: retire = 1'b1;   // HLT
                endcase
            end
            S_EXEC2: begin
                bus_sel = 2'b01;
                ac_ld   = 1'b1;
                retire  = 1'b1;
                case (opcode)
                    OP_ADD:  alu_op = 2'b01;
                    OP_AND:  alu_op = 2'b10;
                    default: alu_op = 2'b00;
                endcase
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            opcode      <= OP_LDA;
            instr_count <= '0;
        end else begin
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
            case (state)
                S_IDLE:   state <= S_FETCH1;
                S_FETCH1: state <= S_FETCH2;
                S_FETCH2: if (mem_ready) state <= S_FETCH3;
                S_FETCH3: begin
                    opcode <= op_t'(bus_in[7:5]);
                    state  <= S_EXEC1;
                end
                S_EXEC1: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_AND: if (mem_ready) state <= S_EXEC2;
                        OP_STA:  if (mem_ready) state <= S_FETCH1;
                        OP_HLT:  state <= S_HALT;
                        default: state <= S_FETCH1;
                    endcase
                end
                S_EXEC2: state <= S_FETCH1;
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Testbench for ctrl_sequencer: a table of per-cycle directed vectors covering
// the full instruction set, followed by hand-written sequences for HALT hold,
// asynchronous reset during a memory wait and instruction-counter wrap.

module tb_ctrl_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_in;
    logic       ac_zero;
    logic       mem_ready;
    logic [1:0] bus_sel;
    logic       ar_ld, pc_ld, pc_inc, dr_ld, ac_ld, mem_we, halted;
    logic [1:0] alu_op;
    logic [7:0] instr_count;

    ctrl_sequencer #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_in      (bus_in),
        .ac_zero     (ac_zero),
        .mem_ready   (mem_ready),
        .bus_sel     (bus_sel),
        .ar_ld       (ar_ld),
        .pc_ld       (pc_ld),
        .pc_inc      (pc_inc),
        .dr_ld       (dr_ld),
        .ac_ld       (ac_ld),
        .mem_we      (mem_we),
        .alu_op      (alu_op),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed output word: {bus_sel[1:0], ar_ld, pc_ld, pc_inc, dr_ld, ac_ld, mem_we, alu_op[1:0], halted}
    logic [10:0] outs;
    assign outs = {bus_sel, ar_ld, pc_ld, pc_inc, dr_ld, ac_ld, mem_we, alu_op, halted};

    localparam logic [10:0] O_ZERO  = 11'b00_0_0_0_0_0_0_00_0;
    localparam logic [10:0] O_F1    = 11'b10_1_0_0_0_0_0_00_0;
    localparam logic [10:0] O_F2    = 11'b00_0_0_1_1_0_0_00_0;
    localparam logic [10:0] O_F3    = 11'b01_1_0_0_0_0_0_00_0;
    localparam logic [10:0] O_E1M   = 11'b00_0_0_0_1_0_0_00_0;
    localparam logic [10:0] O_LDA2  = 11'b01_0_0_0_0_1_0_00_0;
    localparam logic [10:0] O_ADD2  = 11'b01_0_0_0_0_1_0_01_0;
    localparam logic [10:0] O_AND2  = 11'b01_0_0_0_0_1_0_10_0;
    localparam logic [10:0] O_STA   = 11'b11_0_0_0_0_0_1_00_0;
    localparam logic [10:0] O_PCLD  = 11'b01_0_1_0_0_0_0_00_0;
    localparam logic [10:0] O_JZ0   = 11'b01_0_0_0_0_0_0_00_0;
    localparam logic [10:0] O_NOT   = 11'b00_0_0_0_0_1_0_11_0;
    localparam logic [10:0] O_HALT  = 11'b00_0_0_0_0_0_0_00_1;

    typedef struct {
        logic        rst_n;
        logic [7:0]  bus;
        logic        az;
        logic        mr;
        logic [10:0] exp_outs;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic [7:0] b, input logic az,
                       input logic mr, input logic [10:0] eo, input logic [7:0] ec);
        vec_t v;
        v.rst_n = r; v.bus = b; v.az = az; v.mr = mr; v.exp_outs = eo; v.exp_cnt = ec;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] b, input logic az, input logic mr);
        rst_n = r; bus_in = b; ac_zero = az; mem_ready = mr;
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // rst, bus, ac_zero, mem_ready, expected outputs, expected count
        add(0, 8'h00, 0, 1, O_ZERO, 0);   // in reset
        add(1, 8'h00, 0, 0, O_ZERO, 0);   // IDLE, mem_ready ignored
        add(1, 8'h00, 0, 0, O_F1,   0);   // ADD 0x45
        add(1, 8'h00, 0, 1, O_F2,   0);
        add(1, 8'h45, 0, 0, O_F3,   0);
        add(1, 8'h45, 0, 1, O_E1M,  0);
        add(1, 8'h00, 0, 0, O_ADD2, 0);
        add(1, 8'h00, 0, 1, O_F1,   1);   // 5 cycles after IDLE exit; STA 0x23
        add(1, 8'h00, 0, 0, O_ZERO, 1);   // FETCH2 wait
        add(1, 8'h00, 0, 1, O_F2,   1);
        add(1, 8'h23, 0, 1, O_F3,   1);
        add(1, 8'h00, 0, 0, O_STA,  1);
        add(1, 8'h00, 0, 0, O_STA,  1);
        add(1, 8'h00, 0, 0, O_STA,  1);
        add(1, 8'h00, 0, 1, O_STA,  1);
        add(1, 8'h00, 0, 1, O_F1,   2);   // JZ taken
        add(1, 8'h00, 0, 1, O_F2,   2);
        add(1, 8'hA9, 0, 1, O_F3,   2);
        add(1, 8'h00, 1, 1, O_PCLD, 2);
        add(1, 8'h00, 0, 1, O_F1,   3);   // JZ not taken
        add(1, 8'h00, 0, 1, O_F2,   3);
        add(1, 8'hA9, 0, 1, O_F3,   3);
        add(1, 8'h00, 0, 1, O_JZ0,  3);
        add(1, 8'h00, 0, 1, O_F1,   4);   // LDA 0x07 with EXEC1 wait
        add(1, 8'h00, 0, 1, O_F2,   4);
        add(1, 8'h07, 0, 1, O_F3,   4);
        add(1, 8'h00, 0, 0, O_ZERO, 4);
        add(1, 8'h00, 0, 1, O_E1M,  4);
        add(1, 8'h00, 0, 1, O_LDA2, 4);
        add(1, 8'h00, 0, 0, O_F1,   5);   // AND 0x62
        add(1, 8'h00, 0, 1, O_F2,   5);
        add(1, 8'h62, 0, 0, O_F3,   5);
        add(1, 8'h00, 0, 1, O_E1M,  5);
        add(1, 8'h00, 0, 1, O_AND2, 5);
        add(1, 8'h00, 0, 1, O_F1,   6);   // JMP 0x1F
        add(1, 8'h00, 0, 1, O_F2,   6);
        add(1, 8'h9F, 0, 1, O_F3,   6);
        add(1, 8'h00, 1, 0, O_PCLD, 6);
        add(1, 8'h00, 0, 1, O_F1,   7);   // NOT
        add(1, 8'h00, 0, 1, O_F2,   7);
        add(1, 8'hC0, 0, 1, O_F3,   7);
        add(1, 8'h00, 0, 1, O_NOT,  7);
        add(1, 8'h00, 0, 1, O_F1,   8);   // HLT
        add(1, 8'h00, 0, 1, O_F2,   8);
        add(1, 8'hE0, 0, 1, O_F3,   8);
        add(1, 8'h00, 0, 1, O_ZERO, 8);
        add(1, 8'h00, 0, 1, O_HALT, 9);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].bus, tbl[i].az, tbl[i].mr);
            #1;
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(tbl[i].exp_outs));
            chk($sformatf("vec%0d_cnt", i), 32'(instr_count), 32'(tbl[i].exp_cnt));
            @(negedge clk);
        end

        // HALT holds for 20 cycles regardless of inputs
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i * 13), 1'(i), 1'(i >> 1));
            #1;
            chk("halt_outs", 32'(outs), 32'(O_HALT));
            chk("halt_cnt", 32'(instr_count), 32'd9);
            @(negedge clk);
        end

        // Reset pulse clears halted and count without a clock edge
        rst_n = 1'b0;
        #1;
        chk("halt_rst_outs", 32'(outs), 32'(O_ZERO));
        chk("halt_rst_cnt", 32'(instr_count), 32'd0);
        @(negedge clk);

        // Async reset in the middle of a FETCH2 memory wait
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        @(negedge clk);                       // IDLE -> FETCH1 on next edge
        #1 chk("mw_f1", 32'(outs), 32'(O_F1));
        @(negedge clk);
        #1 chk("mw_wait", 32'(outs), 32'(O_ZERO));
        @(negedge clk);
        mem_ready = 1'b1;
        #1 chk("mw_ready", 32'(outs), 32'(O_F2));
        rst_n = 1'b0;
        #1 chk("mw_rst_outs", 32'(outs), 32'(O_ZERO));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mw_idle", 32'(outs), 32'(O_ZERO));
        @(negedge clk);
        #1 chk("mw_restart_f1", 32'(outs), 32'(O_F1));

        // Counter wrap: 256 back-to-back NOT instructions, 4 cycles each
        rst_n = 1'b0;
        @(negedge clk);
        drive(1'b1, 8'hC0, 1'b0, 1'b1);
        @(negedge clk);                       // IDLE sampled, now FETCH1
        for (int i = 0; i < 255 * 4; i++) @(negedge clk);
        #1;
        chk("wrap_255_cnt", 32'(instr_count), 32'd255);
        chk("wrap_255_outs", 32'(outs), 32'(O_F1));
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1 chk("wrap_not_outs", 32'(outs), 32'(O_NOT));
        @(negedge clk);
        #1;
        chk("wrap_0_cnt", 32'(instr_count), 32'd0);
        chk("wrap_0_outs", 32'(outs), 32'(O_F1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
